// File: rtl/fc_seq.sv
// fc_seq: address/control sequencer for one fully-connected layer pass.
// Walks i over the inputs of each output group and o over the output groups,
// drives the source read / weight address / accumulator controls, and issues
// the destination write strobe LAT cycles after each group's final exec.
module fc_seq #(
    parameter int LAT = 4,
    parameter int WAW = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           run,
    input  logic [12:0]    ss,
    input  logic [12:0]    ds,
    input  logic [12:0]    ia_base,
    input  logic [12:0]    oa_base,
    output logic           busy,
    output logic           done,
    output logic           exec,
    output logic [12:0]    ia,
    output logic [WAW-1:0] wa,
    output logic           init,
    output logic           last,
    output logic           outr,
    output logic [12:0]    oa
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DRAIN
    } state_t;

    // Only the tail stage of the delay line holds a valid entry.
    localparam logic [LAT-1:0] TAIL = LAT'(1) << (LAT - 1);

    state_t         state, state_n;
    logic [12:0]    i, i_n, o, o_n;
    logic [12:0]    ss_r, ss_n, ds_r, ds_n;
    logic [12:0]    iab_r, iab_n, oab_r, oab_n;
    logic [12:0]    ia_n;
    logic [WAW-1:0] wa_n;
    logic           busy_n, done_n, exec_n, init_n, last_n;

    logic [LAT-1:0] vld;
    logic [12:0]    dla [LAT];

    // Next-state and next-output logic; outputs are registered one cycle later.
    always_comb begin
        state_n = state;
        i_n     = i;
        o_n     = o;
        ss_n    = ss_r;
        ds_n    = ds_r;
        iab_n   = iab_r;
        oab_n   = oab_r;
        ia_n    = ia;
        wa_n    = wa;
        busy_n  = busy;
        done_n  = 1'b0;
        exec_n  = 1'b0;
        init_n  = 1'b0;
        last_n  = 1'b0;
        case (state)
            IDLE: begin
                if (run) begin
                    state_n = EXEC;
                    ss_n    = ss;
                    ds_n    = ds;
                    iab_n   = ia_base;
                    oab_n   = oa_base;
                    i_n     = '0;
                    o_n     = '0;
                    ia_n    = ia_base;
                    wa_n    = '0;
                    busy_n  = 1'b1;
                    exec_n  = 1'b1;
                    init_n  = 1'b1;
                    last_n  = (ss == 13'd0);
                end
            end
            EXEC: begin
                if (i == ss_r) begin
                    if (o == ds_r) begin
                        state_n = DRAIN;
                    end else begin
                        i_n    = '0;
                        o_n    = o + 13'd1;
                        ia_n   = iab_r;
                        wa_n   = wa + WAW'(1);
                        exec_n = 1'b1;
                        init_n = 1'b1;
                        last_n = (ss_r == 13'd0);
                    end
                end else begin
                    i_n    = i + 13'd1;
                    ia_n   = ia + 13'd1;
                    wa_n   = wa + WAW'(1);
                    exec_n = 1'b1;
                    last_n = (i + 13'd1 == ss_r);
                end
            end
            DRAIN: begin
                done_n = (vld == TAIL);
                if (vld == '0) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, counters, captured pass parameters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            i     <= '0;
            o     <= '0;
            ss_r  <= '0;
            ds_r  <= '0;
            iab_r <= '0;
            oab_r <= '0;
            ia    <= '0;
            wa    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            exec  <= 1'b0;
            init  <= 1'b0;
            last  <= 1'b0;
        end else begin
            state <= state_n;
            i     <= i_n;
            o     <= o_n;
            ss_r  <= ss_n;
            ds_r  <= ds_n;
            iab_r <= iab_n;
            oab_r <= oab_n;
            ia    <= ia_n;
            wa    <= wa_n;
            busy  <= busy_n;
            done  <= done_n;
            exec  <= exec_n;
            init  <= init_n;
            last  <= last_n;
        end
    end

    // MAC-latency delay line carrying finished-output strobes and their write addresses.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld <= '0;
            for (int k = 0; k < LAT; k++) begin
                dla[k] <= '0;
            end
        end else begin
            vld    <= (vld << 1) | LAT'(exec & last);
            dla[0] <= (exec & last) ? (oab_r + o) : 13'd0;
            for (int k = 1; k < LAT; k++) begin
                dla[k] <= dla[k-1];
            end
        end
    end

    assign outr = vld[LAT-1];
    assign oa   = dla[LAT-1];

endmodule

// File: doc/fc_seq.md
Name: fc_seq

Overview:
- Address/control sequencer for one fully-connected layer pass.
- Drives the source-buffer read port (exec, ia), a linear weight-memory address (wa) and accumulator control (init, last) for the MAC core.
- After the MAC pipeline latency, drives the destination-buffer write strobe (outr, oa) for each finished output.
- Sits between the host run register and the src/dst buffers plus MAC.

Parameters:
LAT, 4, cycles from the exec cycle with last=1 to the matching outr pulse (MAC pipeline depth); legal 1..15
WAW, 16, width of weight address wa

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
run  in  1  start pulse; sampled only in IDLE
ss  in  13  inputs per output minus 1 (0 -> 1 input)
ds  in  13  outputs minus 1 (0 -> 1 output)
ia_base  in  13  first source address
oa_base  in  13  first destination address
busy  out  1  high from the cycle after run is accepted until done
done  out  1  one-cycle pulse at end of pass
exec  out  1  source read / MAC enable
ia  out  13  source read address
wa  out  WAW  weight read address
init  out  1  first exec of an output group; MAC clears accumulator
last  out  1  final exec of an output group
outr  out  1  destination write strobe
oa  out  13  destination write address, valid with outr

Behaviour:
- One clock, clk. Reset is synchronous and active-high on reset. All outputs are registered.
- Reset values: busy, done, exec, init, last and outr are 0; ia, wa and oa are 0; state is IDLE; delay line is cleared.
- ss, ds, ia_base and oa_base are captured on run acceptance. They are ignored afterwards.
- States:
  - IDLE -> EXEC on run.
  - EXEC -> DRAIN on the exec cycle where i==ss and o==ds.
  - DRAIN -> IDLE once the delay line is empty, i.e. the final outr has been issued. done=1 in that same cycle; busy=0 the following cycle.
- Run acceptance: run=1 at edge N in IDLE gives busy=1, exec=1, ia=ia_base, wa=0, init=1 at cycle N+1.
- EXEC runs one exec per cycle with no bubbles. Internal counters are i (0..ss) and o (0..ds).
  - ia = ia_base + i, modulo 2^13 (wraps 8191 -> 0).
  - wa increments by 1 on every exec cycle from 0, so wa = o*(ss+1)+i. It wraps modulo 2^WAW.
  - init=1 when i==0; last=1 when i==ss. With ss=0, init and last are high together every cycle.
  - After last: i <- 0 and o <- o+1.
- Output delay line: LAT-stage shift of {valid, o}, loaded with {exec&last, o}.
  - At its end: outr=1, oa = oa_base + o, modulo 2^13.
  - outr follows exec&last by exactly LAT cycles. Back-to-back outr (ss=0) is legal and occurs every cycle.
- DRAIN: exec=0 and counters hold; only the delay line advances.
- done and outr for the final output are not coincident. outr is at cycle E+LAT (E = final exec); done is at E+LAT+1.
- run while busy or in DRAIN is ignored, with no queuing.
- run in the same cycle done=1 is ignored; a new pass can start from the cycle after done.
- reset mid-pass: next cycle is IDLE with all outputs 0. Pending outr pulses are discarded.
- ss=8191 and ds=8191 are legal. A pass takes (ss+1)*(ds+1)+LAT+1 cycles from run to done inclusive.

Test Plan:
- Reset: assert reset 2 cycles with run=1 -> all outputs 0, no busy; deassert -> still IDLE until run.
- Basic pass, ss=2, ds=1, ia_base=0x10, oa_base=0x20, LAT=4, run at N:
  - N+1..N+6: exec=1; ia = 10,11,12,10,11,12; wa = 0..5; init at N+1 and N+4; last at N+3 and N+6.
  - outr at N+7 (oa=0x20) and N+10 (oa=0x21).
  - done at N+11; busy low at N+12.
- Degenerate ss=0, ds=3, oa_base=0x1FFE -> four consecutive outr with oa = 1FFE, 1FFF, 0000, 0001; init=last=1 on every exec.
- Address wrap: ia_base=0x1FFF, ss=1 -> ia = 1FFF, 0000 per group; wa keeps incrementing without wrap.
- Ignored run: pulse run during EXEC and during the done cycle -> no restart; pass outputs unchanged; a second run one cycle after done starts a clean pass with wa=0.
- Reset mid-pass: basic pass, reset at N+5 -> N+6 all outputs 0, no outr ever issued for the aborted pass; a subsequent run behaves as the basic pass.
